flag_sync_multi: RTL

//   Multi-channel receive-side synchroniser for asynchronous flag/level signals
//   (e.g. toggles from foreign clock domains, MIDI/UART strobes, panel inputs).
//   Per channel: N-stage sync chain, edge-to-pulse conversion, sticky pending

---
 rtl/flag_sync_multi.sv | 125 ++++++++++++
 1 files changed

// File: rtl/flag_sync_multi.sv
// Multi-channel async flag synchroniser: sync chain, edge pulse, sticky pending/ack, overrun.
// Define FLAG_SYNC_FILTER_EN to insert a FILT_LEN-cycle glitch filter after each sync chain.
module flag_sync_multi #(
  parameter int unsigned CH          = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_MODE   = 0,
  parameter int unsigned FILT_LEN    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] async_in,
  input  logic [CH-1:0] ack,
  input  logic [CH-1:0] clr_overrun,
  output logic [CH-1:0] level_out,
  output logic [CH-1:0] pulse_out,
  output logic [CH-1:0] pending,
  output logic [CH-1:0] overrun
);

  if (CH < 1) begin : gen_bad_ch
    $error("flag_sync_multi: CH must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : gen_bad_stages
    $error("flag_sync_multi: SYNC_STAGES must be >= 2");
  end
  if (EDGE_MODE > 2) begin : gen_bad_mode
    $error("flag_sync_multi: EDGE_MODE must be 0, 1 or 2");
  end
  if (FILT_LEN < 1) begin : gen_bad_filt
    $error("flag_sync_multi: FILT_LEN must be >= 1");
  end

  logic [CH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CH-1:0] sync_out;
  logic [CH-1:0] s;
  logic [CH-1:0] evt;
  logic [CH-1:0] prev_q, prev_d;
  logic [CH-1:0] pulse_q, pulse_d;
  logic [CH-1:0] pend_q, pend_d;
  logic [CH-1:0] ovr_q, ovr_d;

  // Plain shift chain: nothing may sit between the metastability flops.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      sync_d[i]   = {sync_q[i][SYNC_STAGES-2:0], async_in[i]};
      sync_out[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

`ifdef FLAG_SYNC_FILTER_EN
  localparam int unsigned CntW = $clog2(FILT_LEN + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(FILT_LEN - 1);

  logic [CH-1:0]           filt_q, filt_d;
  logic [CH-1:0][CntW-1:0] cnt_q, cnt_d;

  // Filter output follows the synchronised level only after FILT_LEN differing cycles in a row.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < CH; i++) begin
      if (sync_out[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntLast) begin
        filt_d[i] = sync_out[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= '0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign s = filt_q;
`else
  assign s = sync_out;
`endif

  always_comb begin
    if (EDGE_MODE == 1) begin
      evt = s & ~prev_q;
    end else if (EDGE_MODE == 2) begin
      evt = ~s & prev_q;
    end else begin
      evt = s ^ prev_q;
    end
    prev_d  = s;
    pulse_d = evt;
    // A new event keeps pending set even when the old one is acked in the same cycle.
    pend_d  = evt | (pend_q & ~ack);
    // Setting overrun beats a simultaneous clear.
    ovr_d   = (ovr_q & ~clr_overrun) | (evt & pend_q & ~ack);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      prev_q  <= '0;
      pulse_q <= '0;
      pend_q  <= '0;
      ovr_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
    end
  end

  assign level_out = s;
  assign pulse_out = pulse_q;
  assign pending   = pend_q;
  assign overrun   = ovr_q;

endmodule
